// File: rtl/fb_pkg.sv
// Shared framebuffer geometry, FIFO entry layout and responder FSM state encoding.
// Latency: n/a (types, constants and one pure address helper).
// Backpressure: n/a. The CLEAR state exists only when FB_PLOT_CLEAR_EN is defined.
package fb_pkg;

  localparam int H_RES      = 320;
  localparam int V_RES      = 240;
  localparam int COLOUR_W   = 3;
  localparam int ADDR_W     = 17;
  localparam int FIFO_DEPTH = 4;
  localparam int X_W        = 10;
  localparam int Y_W        = 9;

  typedef logic [COLOUR_W-1:0] colour_t;
  typedef logic [ADDR_W-1:0]   addr_t;

  // One queued pixel: linear address plus colour.
  typedef struct packed {
    addr_t   addr;
    colour_t colour;
  } fb_entry_t;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    STALL
`ifdef FB_PLOT_CLEAR_EN
    , CLEAR
`endif
  } fb_state_t;

  // Row-major linear address; the caller guarantees x/y are in range.
  function automatic addr_t pix_addr(input logic [X_W-1:0] x, input logic [Y_W-1:0] y);
    return addr_t'(y) * addr_t'(H_RES) + addr_t'(x);
  endfunction

endpackage

// File: rtl/fb_plot_responder_if.sv
// Plot request handshake plus framebuffer write port, bundled as one interface.
// Latency: n/a (wiring only).
// Backpressure: plot_ready from the responder stalls drawers; mem_grant stalls the responder.
interface fb_plot_responder_if;
  import fb_pkg::*;

  logic             plot_valid;
  logic             plot_ready;
  logic [X_W-1:0]   plot_x;
  logic [Y_W-1:0]   plot_y;
  colour_t          plot_colour;
  logic             mem_grant;
  logic             mem_we;
  addr_t            mem_addr;
  colour_t          mem_wdata;

  modport slave (
    input  plot_valid, plot_x, plot_y, plot_colour, mem_grant,
    output plot_ready, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output plot_valid, plot_x, plot_y, plot_colour, mem_grant,
    input  plot_ready, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/fb_plot_fifo.sv
// Small synchronous FIFO holding queued pixel writes (DEPTH must be a power of two).
// Latency: a pushed entry is visible on pop_dat the cycle after the push edge.
// Backpressure: pushes while full and pops while empty are ignored; callers gate on full/empty.
module fb_plot_fifo #(
  parameter int WIDTH = 20,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_dat,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] store [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign pop_dat = store[rd_ptr];

  // Storage array; no reset needed since count gates every read.
  always_ff @(posedge clock) begin
    if (do_push) store[wr_ptr] <= push_dat;
  end

  // Pointers and occupancy; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

endmodule

// File: rtl/fb_plot_responder.sv
// Clips plot requests, queues {addr,colour} and drains them as single-cycle framebuffer writes.
// Latency: request accepted at edge N gives mem_we high after edge N+1 when granted; one write/cycle.
// Backpressure: plot_ready drops when the queue is full (or while clearing); mem_grant=0 holds writes.
// Optional FB_PLOT_CLEAR_EN adds a full-screen clear engine (clear_start/clear_colour/clear_done).
module fb_plot_responder
  import fb_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  fb_plot_responder_if.slave  bus,
`ifdef FB_PLOT_CLEAR_EN
  input  logic                clear_start,
  input  colour_t             clear_colour,
  output logic                clear_done,
`endif
  output logic [15:0]         clip_count,
  output logic                busy
);

  localparam addr_t LAST_ADDR = addr_t'(H_RES * V_RES - 1);

  fb_state_t state;
  fb_entry_t push_entry;
  fb_entry_t head;
  logic      fifo_full;
  logic      fifo_empty;
  logic      accept;
  logic      in_range;
  logic      push;
  logic      pop;
  logic      mem_we_q;
  addr_t     mem_addr_q;
  colour_t   mem_wdata_q;
`ifdef FB_PLOT_CLEAR_EN
  addr_t     clr_addr;
  logic      clr_fin;
  logic      clr_pend;
`endif

  // Ready depends on registered state only, never on plot_valid.
`ifdef FB_PLOT_CLEAR_EN
  assign bus.plot_ready = !fifo_full && (state != CLEAR);
`else
  assign bus.plot_ready = !fifo_full;
`endif

  assign accept   = bus.plot_valid && bus.plot_ready;
  assign in_range = (bus.plot_x < X_W'(H_RES)) && (bus.plot_y < Y_W'(V_RES));
  assign push     = accept && in_range;

  assign push_entry.addr   = pix_addr(bus.plot_x, bus.plot_y);
  assign push_entry.colour = bus.plot_colour;

  // Drain whenever granted; the clear engine owns the port while it runs.
`ifdef FB_PLOT_CLEAR_EN
  assign pop = !fifo_empty && bus.mem_grant && (state != CLEAR);
`else
  assign pop = !fifo_empty && bus.mem_grant;
`endif

  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign busy          = !fifo_empty || mem_we_q || (state != IDLE);

  fb_plot_fifo #(
    .WIDTH ($bits(fb_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (push),
    .push_dat (push_entry),
    .pop      (pop),
    .pop_dat  (head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // Write-port FSM: registers one write strobe per popped entry (or clear address).
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
`ifdef FB_PLOT_CLEAR_EN
      clr_addr    <= '0;
      clr_fin     <= 1'b0;
      clr_pend    <= 1'b0;
      clear_done  <= 1'b0;
`endif
    end else begin
      mem_we_q <= pop;
      if (pop) begin
        mem_addr_q  <= head.addr;
        mem_wdata_q <= head.colour;
      end
`ifdef FB_PLOT_CLEAR_EN
      clear_done <= 1'b0;
      // A clear request arriving mid-drain waits until the queue is empty.
      if (clear_start && state != CLEAR) clr_pend <= 1'b1;
`endif
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            state <= WRITE;
`ifdef FB_PLOT_CLEAR_EN
          end else if (clr_pend || clear_start) begin
            state    <= CLEAR;
            clr_pend <= 1'b0;
            clr_addr <= '0;
            clr_fin  <= 1'b0;
`endif
          end
        end
        WRITE: begin
          if (fifo_empty)          state <= IDLE;
          else if (!bus.mem_grant) state <= STALL;
        end
        STALL: begin
          if (fifo_empty)         state <= IDLE;
          else if (bus.mem_grant) state <= WRITE;
        end
`ifdef FB_PLOT_CLEAR_EN
        CLEAR: begin
          if (clr_fin) begin
            clear_done <= 1'b1;
            clr_fin    <= 1'b0;
            state      <= IDLE;
          end else if (bus.mem_grant) begin
            mem_we_q    <= 1'b1;
            mem_addr_q  <= clr_addr;
            mem_wdata_q <= clear_colour;
            if (clr_addr == LAST_ADDR) clr_fin  <= 1'b1;
            else                       clr_addr <= clr_addr + addr_t'(1);
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

  // Saturating count of accepted requests that fell outside the screen.
  always_ff @(posedge clock) begin
    if (reset) begin
      clip_count <= '0;
    end else if (accept && !in_range && clip_count != 16'hFFFF) begin
      clip_count <= clip_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_fb_plot_responder.sv
// Directed bench for fb_plot_responder: table of single plots, then multi-cycle sequences.
// Latency: checks the two-edge request-to-write timing directly.
// Backpressure: exercises grant=0 queue fill, grant toggling and mid-queue reset.
module tb_fb_plot_responder;
  import fb_pkg::*;

  logic        clock;
  logic        reset;
  logic [15:0] clip_count;
  logic        busy;
`ifdef FB_PLOT_CLEAR_EN
  logic        clear_start;
  colour_t     clear_colour;
  logic        clear_done;
`endif

  fb_plot_responder_if bus ();

  fb_plot_responder dut (
    .clock        (clock),
    .reset        (reset),
    .bus          (bus.slave),
`ifdef FB_PLOT_CLEAR_EN
    .clear_start  (clear_start),
    .clear_colour (clear_colour),
    .clear_done   (clear_done),
`endif
    .clip_count   (clip_count),
    .busy         (busy)
  );

  initial clock = 1'b0;
  always #10 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [9:0] x;
    logic [8:0] y;
    logic [2:0] c;
    bit         clip;
    int         addr;
    int         clips;
  } vec_t;

  vec_t        tbl [8];
  logic [19:0] wr_q [$];
  logic        grant_q;
  bit          blk_done;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Grant as seen by the DUT at each rising edge.
  always @(posedge clock) grant_q <= bus.mem_grant;

  // Log every write and confirm the port was granted at the edge that issued it.
  always @(negedge clock) begin
    if (bus.mem_we === 1'b1) begin
      wr_q.push_back({bus.mem_addr, bus.mem_wdata});
      check("write_without_grant", {31'd0, grant_q}, 32'd1);
    end
  end

  // Present one request at a falling edge; returns at the falling edge after acceptance.
  task automatic do_push(input logic [9:0] x, input logic [8:0] y, input logic [2:0] c);
    bit done = 1'b0;
    bus.plot_x      = x;
    bus.plot_y      = y;
    bus.plot_colour = c;
    bus.plot_valid  = 1'b1;
    for (int k = 0; k < 200 && !done; k++) begin
      if (bus.plot_ready) done = 1'b1;
      @(negedge clock);
    end
    bus.plot_valid = 1'b0;
    if (!done) check("push_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    tbl[0] = '{10'd5,    9'd7,   3'b001, 1'b0, 2245,  0};
    tbl[1] = '{10'd320,  9'd0,   3'b010, 1'b1, 0,     1};
    tbl[2] = '{10'd0,    9'd240, 3'b011, 1'b1, 0,     2};
    tbl[3] = '{10'd319,  9'd239, 3'b100, 1'b0, 76799, 2};
    tbl[4] = '{10'd0,    9'd0,   3'b111, 1'b0, 0,     2};
    tbl[5] = '{10'd1023, 9'd511, 3'b101, 1'b1, 0,     3};
    tbl[6] = '{10'd0,    9'd1,   3'b010, 1'b0, 320,   3};
    tbl[7] = '{10'd100,  9'd50,  3'b101, 1'b0, 16100, 3};

    reset           = 1'b1;
    bus.plot_valid  = 1'b0;
    bus.plot_x      = '0;
    bus.plot_y      = '0;
    bus.plot_colour = '0;
    bus.mem_grant   = 1'b1;
`ifdef FB_PLOT_CLEAR_EN
    clear_start  = 1'b0;
    clear_colour = '0;
`endif
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    check("reset_mem_we",     {31'd0, bus.mem_we},     32'd0);
    check("reset_mem_addr",   32'(bus.mem_addr),       32'd0);
    check("reset_mem_wdata",  32'(bus.mem_wdata),      32'd0);
    check("reset_clip_count", 32'(clip_count),         32'd0);
    check("reset_busy",       {31'd0, busy},           32'd0);
    check("reset_plot_ready", {31'd0, bus.plot_ready}, 32'd1);

    // Single plots with grant held high.
    for (int i = 0; i < 8; i++) begin
      do_push(tbl[i].x, tbl[i].y, tbl[i].c);
      if (!tbl[i].clip) begin
        check("vec_busy_queued", {31'd0, busy}, 32'd1);
        @(negedge clock);
        check("vec_mem_we",    {31'd0, bus.mem_we}, 32'd1);
        check("vec_mem_addr",  32'(bus.mem_addr),   32'(tbl[i].addr));
        check("vec_mem_wdata", 32'(bus.mem_wdata),  32'(tbl[i].c));
        @(negedge clock);
        check("vec_we_single", {31'd0, bus.mem_we}, 32'd0);
      end else begin
        check("vec_clip_no_we", {31'd0, bus.mem_we}, 32'd0);
        @(negedge clock);
        check("vec_clip_no_we", {31'd0, bus.mem_we}, 32'd0);
        @(negedge clock);
      end
      check("vec_busy_idle",  {31'd0, busy},   32'd0);
      check("vec_clip_count", 32'(clip_count), 32'(tbl[i].clips));
    end

    // Fill the queue with no grant, then release it.
    bus.mem_grant = 1'b0;
    wr_q.delete();
    for (int i = 1; i <= 4; i++) do_push(10'(i), 9'd0, 3'(i));
    check("bp_ready_full", {31'd0, bus.plot_ready}, 32'd0);
    check("bp_busy",       {31'd0, busy},           32'd1);
    check("bp_no_writes",  32'(wr_q.size()),        32'd0);
    bus.mem_grant = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clock);
      check("bp_we",    {31'd0, bus.mem_we}, 32'd1);
      check("bp_addr",  32'(bus.mem_addr),   32'(i));
      check("bp_wdata", 32'(bus.mem_wdata),  32'(i));
      if (i == 1) check("bp_ready_after_pop", {31'd0, bus.plot_ready}, 32'd1);
    end
    @(negedge clock);
    check("bp_we_done", {31'd0, bus.mem_we}, 32'd0);
    check("bp_idle",    {31'd0, busy},       32'd0);

    // 10x10 block at (20,20) with the grant toggling underneath.
    wr_q.delete();
    blk_done = 1'b0;
    fork
      begin
        for (int r = 0; r < 10; r++)
          for (int c = 0; c < 10; c++)
            do_push(10'(20 + c), 9'(20 + r), 3'((r + c) % 8));
        blk_done = 1'b1;
      end
      begin
        int cyc = 0;
        while (!blk_done) begin
          @(negedge clock);
          bus.mem_grant = ((cyc * 7) % 5) != 0;
          cyc++;
        end
      end
    join
    bus.mem_grant = 1'b1;
    begin
      bit idle = 1'b0;
      for (int k = 0; k < 100 && !idle; k++) begin
        @(negedge clock);
        if (!busy) idle = 1'b1;
      end
      check("blk_drain", {31'd0, idle}, 32'd1);
    end
    check("blk_count", 32'(wr_q.size()), 32'd100);
    for (int i = 0; i < 100 && i < wr_q.size(); i++) begin
      check("blk_addr",  32'(wr_q[i][19:3]), 32'((20 + i / 10) * 320 + 20 + i % 10));
      check("blk_wdata", 32'(wr_q[i][2:0]),  32'((i / 10 + i % 10) % 8));
    end

    // Reset with three pixels queued and a nonzero clip count.
    bus.mem_grant = 1'b0;
    do_push(10'd1, 9'd1, 3'd1);
    do_push(10'd2, 9'd1, 3'd2);
    do_push(10'd400, 9'd1, 3'd3);
    do_push(10'd3, 9'd1, 3'd3);
    check("rst_pre_clip", 32'(clip_count), 32'd4);
    wr_q.delete();
    bus.mem_grant = 1'b1;
    reset = 1'b1;
    @(negedge clock);
    check("rst_no_we", {31'd0, bus.mem_we}, 32'd0);
    reset = 1'b0;
    @(negedge clock);
    check("rst_busy",       {31'd0, busy},           32'd0);
    check("rst_clip_count", 32'(clip_count),         32'd0);
    check("rst_plot_ready", {31'd0, bus.plot_ready}, 32'd1);
    repeat (4) @(negedge clock);
    check("rst_discarded", 32'(wr_q.size()), 32'd0);

`ifdef FB_PLOT_CLEAR_EN
    // Full-screen clear with grant held high.
    begin
      int  exp_a    = 0;
      int  bad_a    = 0;
      int  rdy_hi   = 0;
      int  dones    = 0;
      bit  finished = 1'b0;
      clear_colour = 3'b000;
      clear_start  = 1'b1;
      @(negedge clock);
      clear_start = 1'b0;
      for (int k = 0; k < 78000 && !finished; k++) begin
        if (bus.mem_we) begin
          if (32'(bus.mem_addr) != exp_a || bus.mem_wdata != 3'b000) bad_a++;
          if (bus.plot_ready) rdy_hi++;
          exp_a++;
        end
        if (clear_done) begin
          dones++;
          finished = 1'b1;
        end
        @(negedge clock);
      end
      for (int k = 0; k < 4; k++) begin
        if (clear_done) dones++;
        @(negedge clock);
      end
      check("clr_writes",   32'(exp_a),  32'd76800);
      check("clr_bad_addr", 32'(bad_a),  32'd0);
      check("clr_ready_hi", 32'(rdy_hi), 32'd0);
      check("clr_done_cnt", 32'(dones),  32'd1);
      check("clr_ready_after", {31'd0, bus.plot_ready}, 32'd1);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
